// File: rtl/image1_brighten_pkg.sv
// Shared RIPL stream definitions for the image1 brighten actor: widths, queue states and the
// saturating add used by point-op actors.
package image1_brighten_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned COUNT_W    = 16;

  typedef logic [COUNT_W-1:0] count_t;

  // Queue occupancy doubles as the FIFO state.
  localparam logic [1:0] OccEmpty = 2'd0;
  localparam logic [1:0] OccOne   = 2'd1;
  localparam logic [1:0] OccTwo   = 2'd2;

  // Saturating add clamped to w bits; operands must already fit in w bits (w <= 16).
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                          input int unsigned w);
    logic [16:0] sum;
    logic [16:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (17'd1 << w) - 17'd1;
    return (sum > max_v) ? max_v[15:0] : sum[15:0];
  endfunction

endpackage

// File: rtl/image1_brighten_q2.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers; caller never pushes when full or pops
// when empty.
module image1_brighten_q2
  import image1_brighten_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OccEmpty: if (push) occ_d = OccOne;
      OccOne: begin
        if (push && !pop) occ_d = OccTwo;
        else if (pop && !push) occ_d = OccEmpty;
      end
      OccTwo: if (pop) occ_d = OccOne;
      default: occ_d = OccEmpty;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ_q    <= OccEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge CLK) begin
    if (!RESET && push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/image1_brighten.sv
// RIPL brighten actor: adds a saturating offset to each image1 pixel, queues results two deep
// and flags the last pixel of every frame.
module image1_brighten
  import image1_brighten_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned OFFSET       = 50,
  parameter int unsigned FRAME_PIXELS = 65536,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               In1_SEND,
  input  logic [DATA_W-1:0]  In1_DATA,
  input  logic [COUNT_W-1:0] In1_COUNT,
  output logic               In1_ACK,
  input  logic               Out1_RDY,
  input  logic               Out1_ACK,
  output logic               Out1_SEND,
  output logic [DATA_W-1:0]  Out1_DATA,
  output logic [COUNT_W-1:0] Out1_COUNT,
  output logic               FRAME_DONE
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_PIXELS - 1);

  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] sat_pix;
  logic              push;
  logic              pop;
  logic              frame_last;
  logic [CNT_W-1:0]  cnt_q;
  logic              unused_inputs;

  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

  assign sat_pix = DATA_W'(sat_add(16'(In1_DATA), 16'(OFFSET), DATA_W));

  // Accept never looks at Out1_RDY: a full queue refuses even while it is draining.
  assign push = In1_SEND & (occ != OccTwo) & ~RESET;
  assign pop  = (occ != OccEmpty) & Out1_RDY & ~RESET;

  image1_brighten_q2 #(
    .DATA_W (DATA_W)
  ) u_q2 (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (sat_pix),
    .dout  (head),
    .occ   (occ)
  );

  assign frame_last = (cnt_q == LastIdx);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= frame_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign In1_ACK    = push;
  assign Out1_SEND  = pop;
  assign Out1_DATA  = (occ != OccEmpty && !RESET) ? head : '0;
  assign Out1_COUNT = {{(COUNT_W-1){1'b0}}, pop};
  assign FRAME_DONE = pop & frame_last;

endmodule
